// File: rtl/vcf_multipole.sv
// Cascaded one-pole LPF/HPF (1..STAGES poles). One shared multiplier is stepped by a small FSM once per audio sample.
// Output updates 2N+1 clocks after the synchronised sample edge; a strobe arriving while busy is dropped and flagged in overrun.
module vcf_multipole #(
  parameter int DATA_W = 16,
  parameter int CUT_W  = 10,
  parameter int COEF_W = 16,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_clk,
  input  logic              lpf,
  input  logic [CUT_W-1:0]  cutoff,
  input  logic [2:0]        order,
  input  logic [DATA_W-1:0] sig_in,
  output logic [DATA_W-1:0] sig_out,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int K_W    = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + 1;
  localparam int H_W    = DATA_W + 2;
  localparam logic [H_W-1:0] MID = H_W'(1) << (DATA_W - 1);

  typedef enum logic [1:0] {IDLE, MUL_X, MUL_Y, DONE} state_t;

  state_t              r_state, w_next;
  logic [2:0]          r_sync;
  logic [DATA_W-1:0]   r_x0;
  logic [COEF_W-1:0]   r_beta;
  logic                r_lpf;
  logic [3:0]          r_n;
  logic [K_W-1:0]      r_k;
  logic [PROD_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_y [STAGES];

  logic                w_start;
  logic [3:0]          w_n;
  logic [COEF_W-1:0]   w_beta, w_alpha;
  logic                w_last;
  logic [DATA_W-1:0]   w_x_k, w_y_k, w_mul_a, w_y_new, w_hpf_sat;
  logic [COEF_W-1:0]   w_mul_b;
  logic [PROD_W-1:0]   w_prod;
  logic [ACC_W-1:0]    w_sum;
  logic [H_W-1:0]      w_hpf;

  // Bits [1:0] form the synchroniser; bit 2 is the edge-detect history.
  assign w_start = r_sync[1] & ~r_sync[2];
  assign w_beta  = COEF_W'(cutoff) << (COEF_W - CUT_W);
  assign w_alpha = ~r_beta;
  assign w_last  = ((4'(r_k) + 4'd1) == r_n);

  always_comb begin
    w_n = {1'b0, order};
    if (order == 3'd0)
      w_n = 4'd1;
    else if (w_n > 4'(STAGES))
      w_n = 4'(STAGES);
  end

  // Stage k input is the original sample for k = 0, else the freshly updated previous stage.
  assign w_x_k = (r_k == '0) ? r_x0 : r_y[r_k - K_W'(1)];
  assign w_y_k = r_y[r_k];

  always_comb begin
    w_mul_a = w_x_k;
    w_mul_b = r_beta;
    if (r_state == MUL_Y) begin
      w_mul_a = w_y_k;
      w_mul_b = w_alpha;
    end
  end

  assign w_prod  = PROD_W'(w_mul_a) * PROD_W'(w_mul_b);
  assign w_sum   = ACC_W'(r_acc) + ACC_W'(w_prod);
  assign w_y_new = DATA_W'(w_sum >> COEF_W);

  assign w_hpf = H_W'(r_x0) - H_W'(w_y_k) + MID;
  always_comb begin
    w_hpf_sat = w_hpf[DATA_W-1:0];
    if (w_hpf[H_W-1])
      w_hpf_sat = '0;
    else if (w_hpf[DATA_W])
      w_hpf_sat = '1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = MUL_X;
      MUL_X:   w_next = MUL_Y;
      MUL_Y:   w_next = w_last ? DONE : MUL_X;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= '0;
      r_x0      <= '0;
      r_beta    <= '0;
      r_lpf     <= 1'b0;
      r_n       <= 4'd1;
      r_k       <= '0;
      r_acc     <= '0;
      sig_out   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < STAGES; i++) r_y[i] <= '0;
    end else begin
      r_sync    <= {r_sync[1:0], sample_clk};
      out_valid <= 1'b0;
      if (w_start && (r_state != IDLE))
        overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_x0   <= sig_in;
            r_beta <= w_beta;
            r_lpf  <= lpf;
            r_n    <= w_n;
            r_k    <= '0;
            busy   <= 1'b1;
          end
        end
        MUL_X: r_acc <= w_prod;
        MUL_Y: begin
          r_y[r_k] <= w_y_new;
          if (!w_last)
            r_k <= r_k + K_W'(1);
        end
        DONE: begin
          sig_out   <= r_lpf ? w_y_k : w_hpf_sat;
          out_valid <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vcf_multipole.sv
// Randomised and directed bench for vcf_multipole against a per-sample arithmetic model of the pole cascade.
module tb_vcf_multipole;
  localparam int DATA_W = 16;
  localparam int CUT_W  = 10;
  localparam int COEF_W = 16;
  localparam int STAGES = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              sample_clk;
  logic              lpf;
  logic [CUT_W-1:0]  cutoff;
  logic [2:0]        order;
  logic [DATA_W-1:0] sig_in;
  logic [DATA_W-1:0] sig_out;
  logic              out_valid;
  logic              busy;
  logic              overrun;

  int     total = 0;
  int     bad   = 0;
  longint st [STAGES];

  always #5 clk = ~clk;

  vcf_multipole #(.DATA_W(DATA_W), .CUT_W(CUT_W), .COEF_W(COEF_W), .STAGES(STAGES)) dut (
    .clk(clk), .reset_n(reset_n), .sample_clk(sample_clk), .lpf(lpf), .cutoff(cutoff),
    .order(order), .sig_in(sig_in), .sig_out(sig_out), .out_valid(out_valid),
    .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int eff_n(input int ord);
    if (ord == 0) return 1;
    if (ord > STAGES) return STAGES;
    return ord;
  endfunction

  task automatic model_step(input bit l, input int cut, input int ord, input longint x,
                            output longint res);
    longint beta, alpha, xv;
    beta  = longint'(cut) << (COEF_W - CUT_W);
    alpha = (longint'(1) << COEF_W) - 1 - beta;
    xv    = x;
    for (int k = 0; k < eff_n(ord); k++) begin
      st[k] = (xv * beta + st[k] * alpha) >> COEF_W;
      xv    = st[k];
    end
    if (l) res = xv;
    else begin
      res = x - xv + (longint'(1) << (DATA_W - 1));
      if (res < 0) res = 0;
      if (res > 65535) res = 65535;
    end
  endtask

  task automatic apply_inputs(input bit l, input int cut, input int ord, input longint x);
    lpf    = l;
    cutoff = CUT_W'(cut);
    order  = 3'(ord);
    sig_in = DATA_W'(x);
  endtask

  // Raises sample_clk just after a falling edge, so the start edge is the third rising edge.
  task automatic run_sample(input bit l, input int cut, input int ord, input longint x,
                            input bit scramble, output longint got);
    longint exp;
    int     lat  = 0;
    bit     seen = 1'b0;
    @(negedge clk);
    apply_inputs(l, cut, ord, x);
    sample_clk = 1'b1;
    model_step(l, cut, ord, x, exp);
    for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 2) sample_clk = 1'b0;
      if (cyc == 3) chk("busy_after_start", longint'(busy), 1);
      if (cyc == 4 && scramble)
        apply_inputs(1'($urandom), int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)),
                     longint'($urandom_range(0, 65535)));
      if (out_valid) begin
        seen = 1'b1;
        lat  = cyc;
      end
    end
    got = longint'(sig_out);
    if (!seen) chk("valid_timeout", 0, 1);
    else begin
      chk("latency", longint'(lat), longint'(2 * eff_n(ord) + 4));
      chk("sig_out", longint'(sig_out), exp);
      chk("busy_at_done", longint'(busy), 0);
      @(negedge clk);
      chk("valid_pulse_width", longint'(out_valid), 0);
    end
  endtask

  initial begin
    longint got, prev, exp, first_out;
    int     pulses, first_lat;

    reset_n    = 1'b0;
    sample_clk = 1'b0;
    apply_inputs(1'b1, 0, 1, 0);
    for (int i = 0; i < STAGES; i++) st[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sig_out", longint'(sig_out), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_overrun", longint'(overrun), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      run_sample(1'b1, 0, 4, 50000, 1'b0, got);
      chk("cut0_lpf_hold", got, 0);
    end
    run_sample(1'b0, 0, 4, 50000, 1'b0, got);
    chk("cut0_hpf_sat", got, 65535);

    run_sample(1'b1, 1023, 1, 40000, 1'b0, got);
    chk("lpf_step_first", got, 39960);
    prev = got;
    for (int i = 0; i < 6; i++) begin
      run_sample(1'b1, 1023, 1, 40000, 1'b0, got);
      chk("lpf_monotonic", longint'(got >= prev && got <= 40000), 1);
      prev = got;
    end

    run_sample(1'b1, 700, 0, 12000, 1'b0, got);
    run_sample(1'b0, 300, 7, 60000, 1'b0, got);
    run_sample(1'b1, 900, 4, 100, 1'b0, got);

    for (int i = 0; i < 200; i++) run_sample(1'b0, 512, 2, 30000, 1'b0, got);
    chk("hpf_dc_band", longint'(got >= 32704 && got <= 32832), 1);

    for (int i = 0; i < 30; i++)
      run_sample(1'($urandom), int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)),
                 longint'($urandom_range(0, 65535)), 1'b1, got);
    chk("no_overrun_yet", longint'(overrun), 0);

    // Second strobe lands four clocks after the first start edge.
    pulses = 0; first_lat = 0; first_out = 0;
    @(negedge clk);
    apply_inputs(1'b1, 300, 4, 12345);
    sample_clk = 1'b1;
    model_step(1'b1, 300, 4, 12345, exp);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 1) sample_clk = 1'b0;
      if (cyc == 4) begin
        sample_clk = 1'b1;
        sig_in     = 16'd999;
        cutoff     = 10'd1000;
      end
      if (cyc == 6) sample_clk = 1'b0;
      if (out_valid) begin
        pulses++;
        if (pulses == 1) begin
          first_lat = cyc;
          first_out = longint'(sig_out);
        end
      end
    end
    chk("ovr_pulses", longint'(pulses), 1);
    chk("ovr_latency", longint'(first_lat), 12);
    chk("ovr_sig_out", first_out, exp);
    chk("ovr_flag", longint'(overrun), 1);
    run_sample(1'b1, 400, 3, 20000, 1'b1, got);
    chk("ovr_sticky", longint'(overrun), 1);

    // Reset three clocks after the start edge of an order-4 sample.
    @(negedge clk);
    apply_inputs(1'b1, 600, 4, 45000);
    sample_clk = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 2) sample_clk = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    chk("midrst_sig_out", longint'(sig_out), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_overrun", longint'(overrun), 0);
    for (int i = 0; i < STAGES; i++) st[i] = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_sample(1'b1, 600, 4, 45000, 1'b0, got);
    run_sample(1'b0, 250, 3, 7000, 1'b1, got);
    chk("post_rst_overrun", longint'(overrun), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vcf_multipole.md
Name: vcf_multipole

Overview:
Parametrised cascaded one-pole voltage-controlled filter for the synth audio path. It supports 1..STAGES poles, runtime LPF/HPF mode, and parametrised data and cutoff widths. A single time-multiplexed multiplier runs under a small FSM, once per audio sample strobe. It sits between the oscillator/mixer output and the VCA, in the same slot as the existing single-pole filter.

Parameters:
DATA_W, 16, width of unsigned (offset-binary) audio in/out
CUT_W, 10, width of cutoff control word
COEF_W, 16, coefficient width; CUT_W <= COEF_W
STAGES, 4, maximum number of cascaded poles (1..8)

Ports:
clk  in  1  system clock
reset_n  in  1  reset
sample_clk  in  1  audio sample clock, asynchronous to clk, one new sample per rising edge
lpf  in  1  1 = lowpass, 0 = highpass
cutoff  in  CUT_W  cutoff control, unsigned
order  in  3  requested pole count
sig_in  in  DATA_W  input sample, unsigned offset-binary
sig_out  out  DATA_W  filtered sample, registered
out_valid  out  1  one-cycle pulse when sig_out updates
busy  out  1  high while a sample is being computed
overrun  out  1  sticky: a sample strobe arrived while busy

Behaviour:
- Reset is reset_n, asynchronous, active-low; clock is clk. Reset clears sig_out, out_valid, busy, overrun, all stage state registers and the synchroniser, and forces the FSM to IDLE. Reset mid-computation discards the sample in progress.
- sample_clk passes through a 2-flop synchroniser plus rising-edge detect. The internal start pulse is high for one cycle; call that edge S.
- Coefficients: beta = cutoff left-justified to COEF_W (low bits zero); alpha = (2^COEF_W - 1) - beta.
- Effective order N = clamp(order, 1, STAGES). order = 0 behaves as 1.
- FSM states: IDLE, MUL_X, MUL_Y, DONE.
- IDLE: at edge S, latch sig_in (x0), beta, lpf and N; set stage index k = 0; set busy = 1; go to MUL_X.
- MUL_X: acc <= x_k * beta, where x_0 = latched input and x_k = new y_{k-1} for k > 0. Go to MUL_Y.
- MUL_Y: y_k <= (acc + yprev_k * alpha) >> COEF_W, truncated to DATA_W. The result cannot overflow (convex combination); accumulator width is DATA_W + COEF_W + 1.
  - If k < N-1: k++ and go to MUL_X.
  - Otherwise go to DONE.
- DONE:
  - LPF: sig_out <= y_{N-1}.
  - HPF: sig_out <= x0 - y_{N-1} + 2^(DATA_W-1), saturated to [0, 2^DATA_W - 1].
  - out_valid = 1 for this one cycle; busy = 0; return to IDLE.
- Latency: sig_out and out_valid change on edge S + 2N + 1. busy is high for edges S+1 .. S+2N+1 exclusive of the last.
- Stages k >= N keep their state untouched. Raising order later resumes those stages from their stale state; this is allowed.
- Inputs change mid-computation: no effect; the latched values are used.
- A start pulse while busy: ignored (no restart); overrun <= 1, sticky until reset. A start pulse in the same cycle DONE completes is also treated as overrun.
- cutoff = 0: beta = 0, so stage state holds (LPF output frozen).
- cutoff = max: alpha = 2^(COEF_W-CUT_W) - 1, giving near pass-through.

Test Plan:
- Reset: assert reset_n = 0 mid-computation (order 4, after 3 cycles) -> sig_out = 0, busy = 0, out_valid = 0, overrun = 0. Next strobe after release computes from zeroed state.
- LPF step: order 1, cutoff 1023, sig_in 40000, first strobe -> sig_out = 39960 (40000 * 65472 >> 16). Repeated strobes converge monotonically to ≤ 40000.
- Latency: order 4 -> out_valid exactly 9 clk edges after S, for one cycle. order 0 -> behaves as 1 (3 edges). order 7 with STAGES = 4 -> clamped (9 edges).
- cutoff 0, LPF, sig_in 50000 for 20 strobes -> sig_out stays 0. Switch to HPF -> sig_out = min(50000 + 32768, 65535) = 65535 (saturation).
- HPF DC: order 2, cutoff 512, sig_in 30000 held for 200 strobes -> sig_out settles within 32768 ± 64.
- Overrun: order 4; second sample_clk rising edge timed so its start pulse lands 4 cycles after S -> computation unaffected, one out_valid, overrun = 1 and held through later samples until reset.
